// File: rtl/bus_cycle_pkg.sv
// Shared types for the bus-cycle controller: one-hot cycle states and the latched operation kind.
package bus_cycle_pkg;

    typedef enum logic [4:0] {
        T1 = 5'b00001,
        T2 = 5'b00010,
        TW = 5'b00100,
        T3 = 5'b01000,
        T4 = 5'b10000
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// CPU-side request signals and peripheral-side strobes of the bus-cycle controller.
// The controller uses the master modport; the CPU/peripheral environment uses slave.
interface bus_cycle_ctrl_if #(
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 8,
    parameter int unsigned NCH  = 4,
    parameter int unsigned WS_W = 3
);
    logic                ale;
    logic                io_m;
    logic [AW-1:0]       ad_in;
    logic                rd_req_n;
    logic                wr_req_n;
    logic                ready;
    logic [NCH*WS_W-1:0] ws_cfg;
    logic [DW-1:0]       din;
    logic                ior_n;
    logic                iow_n;
    logic                memr_n;
    logic                memw_n;
    logic [NCH-1:0]      cs_n;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       rdata;
    logic                rdata_vld;
    logic                busy;
    logic                err;

    modport master (
        input  ale, io_m, ad_in, rd_req_n, wr_req_n, ready, ws_cfg, din,
        output ior_n, iow_n, memr_n, memw_n, cs_n, addr, rdata, rdata_vld, busy, err
    );

    modport slave (
        output ale, io_m, ad_in, rd_req_n, wr_req_n, ready, ws_cfg, din,
        input  ior_n, iow_n, memr_n, memw_n, cs_n, addr, rdata, rdata_vld, busy, err
    );

endinterface

// File: rtl/bus_wait_ctr.sv
// Wait-state down-counter for TW; with BUS_TIMEOUT_EN defined it also counts TW cycles
// and flags a timeout on the TIMEOUT-th one.
module bus_wait_ctr #(
    parameter int unsigned WS_W    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            in_tw,
    input  logic [WS_W-1:0] ws_val,
    output logic            ws_done,
    output logic            tmo
);
    logic [WS_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= ws_val;
        end else if (in_tw && cnt_q != '0) begin
            cnt_q <= cnt_q - WS_W'(1);
        end
    end

    assign ws_done = (cnt_q == '0);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW_W = $clog2(TIMEOUT + 1);

    logic [TW_W-1:0] tcnt_q;

    // Cleared on TW entry, so it holds the index of the current TW cycle.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            tcnt_q <= '0;
        end else if (in_tw) begin
            tcnt_q <= tcnt_q + TW_W'(1);
        end
    end

    assign tmo = in_tw && (tcnt_q == TW_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: rtl/bus_cycle_ctrl.sv
// T1-T2-TW-T3-T4 bus-cycle controller with chip-select decode and programmable wait states.
// Defining BUS_TIMEOUT_EN aborts a TW phase that lasts TIMEOUT cycles and pulses err.
module bus_cycle_ctrl
    import bus_cycle_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned WS_W    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    bus_cycle_ctrl_if.master bus
);
    localparam int unsigned CHW = $clog2(NCH);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic            io_q, io_d;
    logic            abort_q, abort_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   rdata_q;
    logic [CHW-1:0]  ch;
    logic [WS_W-1:0] ws_sel;
    logic            ws_load, in_tw, ws_done, tmo, strobe;

    assign ch     = addr_q[AW-1 -: CHW];
    assign ws_sel = bus.ws_cfg[ch*WS_W +: WS_W];
    assign in_tw  = (state_q == TW);

    bus_wait_ctr #(
        .WS_W    (WS_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (ws_load),
        .in_tw   (in_tw),
        .ws_val  (ws_sel),
        .ws_done (ws_done),
        .tmo     (tmo)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        io_d    = io_q;
        addr_d  = addr_q;
        abort_d = abort_q;
        ws_load = 1'b0;
        unique case (state_q)
            T1: begin
                abort_d = 1'b0;
                if (bus.ale) begin
                    addr_d  = bus.ad_in;
                    io_d    = bus.io_m;
                    state_d = T2;
                end
            end
            T2: begin
                if (!bus.rd_req_n) begin
                    op_d    = OP_RD;
                    ws_load = 1'b1;
                    state_d = TW;
                end else if (!bus.wr_req_n) begin
                    op_d    = OP_WR;
                    ws_load = 1'b1;
                    state_d = TW;
                end
            end
            TW: begin
                // A slave that becomes ready on the last allowed cycle still completes.
                if (ws_done && bus.ready) begin
                    state_d = T3;
                end else if (tmo) begin
                    abort_d = 1'b1;
                    state_d = T4;
                end
            end
            T3:      state_d = T4;
            T4:      state_d = T1;
            default: state_d = T1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T1;
            op_q    <= OP_RD;
            io_q    <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            io_q    <= io_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            if (state_q == T3 && op_q == OP_RD) begin
                rdata_q <= bus.din;
            end
        end
    end

    assign strobe     = (state_q == TW) || (state_q == T3);
    assign bus.ior_n  = !(strobe && io_q && op_q == OP_RD);
    assign bus.iow_n  = !(strobe && io_q && op_q == OP_WR);
    assign bus.memr_n = !(strobe && !io_q && op_q == OP_RD);
    assign bus.memw_n = !(strobe && !io_q && op_q == OP_WR);

    always_comb begin
        bus.cs_n = '1;
        if (state_q != T1) begin
            bus.cs_n[ch] = 1'b0;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != T1);
    assign bus.rdata_vld = (state_q == T4) && (op_q == OP_RD) && !abort_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.err       = (state_q == T4) && abort_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: each cycle pushes its expected strobe/cs/data record,
// a negedge monitor pops and compares it at T4. Covers the BUS_TIMEOUT_EN build as well.
module tb_bus_cycle_ctrl;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [3:0] smask;
        int         width;
        logic [3:0] cs_n;
        logic       vld;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_ctrl_if bus ();

    bus_cycle_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb_q[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [7:0] last_rdata = 8'h00;
    int         mon_width  = 0;
    logic [3:0] mon_mask   = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe order {ior_n, iow_n, memr_n, memw_n}; T4 is the first all-high busy cycle
    // after a strobe episode.
    always @(negedge clk) begin
        logic [3:0] strb;
        exp_t       e;
        strb = {bus.ior_n, bus.iow_n, bus.memr_n, bus.memw_n};
        if (rst || !bus.busy) begin
            mon_width = 0;
            mon_mask  = 4'h0;
        end else if (strb != 4'hF) begin
            mon_width++;
            mon_mask |= ~strb;
        end else if (mon_width != 0) begin
            check_eq("sb_pending", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("strobe_sel", mon_mask, e.smask);
                check_eq("strobe_width", mon_width, e.width);
                check_eq("cs_n_t4", bus.cs_n, e.cs_n);
                check_eq("rdata_vld", bus.rdata_vld, e.vld);
                check_eq("err", bus.err, e.err);
                if (e.vld) check_eq("rdata", bus.rdata, e.rdata);
            end
            mon_width = 0;
            mon_mask  = 4'h0;
        end
    end

    // ready is low for the first rdy_low cycles counted from the T2 request cycle.
    task automatic run_cycle(input logic io, input logic [15:0] a, input logic rd_n,
                             input logic wr_n, input int ws, input int rdy_low,
                             input int req_dly, input logic [7:0] data);
        exp_t        e;
        int          tw;
        int          k;
        logic        tmo;
        logic [1:0]  ch;
        logic [11:0] cfg;
        ch  = a[15:14];
        tw  = (rdy_low > ws + 1) ? rdy_low : ws + 1;
        tmo = 1'b0;
`ifdef BUS_TIMEOUT_EN
        if (tw > int'(TIMEOUT)) begin
            tw  = TIMEOUT;
            tmo = 1'b1;
        end
`endif
        e.smask = !rd_n ? (io ? 4'h8 : 4'h2) : (io ? 4'h4 : 4'h1);
        e.width = tmo ? tw : tw + 1;
        e.cs_n  = ~(4'b0001 << ch);
        e.vld   = !rd_n && !tmo;
        if (e.vld) last_rdata = data;
        e.rdata = last_rdata;
        e.err   = tmo;
        sb_q.push_back(e);

        cfg = {4{3'd7}};
        cfg[ch*3 +: 3] = ws[2:0];
        bus.ws_cfg = cfg;
        bus.din    = data;
        @(posedge clk); #1;
        bus.ale   = 1'b1;
        bus.io_m  = io;
        bus.ad_in = a;
        bus.ready = 1'b1;
        @(posedge clk); #1;
        k = 1;
        bus.ale = 1'b0;
        check_eq("busy_t2", bus.busy, 1);
        check_eq("cs_n_t2", bus.cs_n, e.cs_n);
        while (bus.busy && k < 300) begin
            bus.rd_req_n = (k == 1 + req_dly) ? rd_n : 1'b1;
            bus.wr_req_n = (k == 1 + req_dly) ? wr_n : 1'b1;
            bus.ready    = (k > rdy_low + req_dly);
            @(posedge clk); #1;
            k++;
            if (k == 2 + req_dly) bus.ws_cfg = '0;
        end
        check_eq("cycle_len", k, tmo ? tw + 3 + req_dly : tw + 4 + req_dly);
        check_eq("rdata_hold", bus.rdata, last_rdata);
        bus.rd_req_n = 1'b1;
        bus.wr_req_n = 1'b1;
        bus.ready    = 1'b1;
    endtask

    initial begin
        bus.ale      = 1'b0;
        bus.io_m     = 1'b0;
        bus.ad_in    = '0;
        bus.rd_req_n = 1'b1;
        bus.wr_req_n = 1'b1;
        bus.ready    = 1'b1;
        bus.ws_cfg   = '0;
        bus.din      = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_strobes", {bus.ior_n, bus.iow_n, bus.memr_n, bus.memw_n}, 4'hF);
        check_eq("rst_cs_n", bus.cs_n, 4'hF);
        check_eq("rst_addr", bus.addr, 16'h0000);
        check_eq("rst_rdata", bus.rdata, 8'h00);
        check_eq("rst_vld", bus.rdata_vld, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.err, 0);
        rst = 1'b0;

        run_cycle(1'b1, 16'h4012, 1'b0, 1'b1, 0, 0, 0, 8'hA5);
        check_eq("addr_latch", bus.addr, 16'h4012);
        run_cycle(1'b0, 16'hC000, 1'b1, 1'b0, 3, 0, 0, 8'h5A);
        run_cycle(1'b0, 16'h0123, 1'b0, 1'b1, 0, 6, 0, 8'h3C);
        run_cycle(1'b1, 16'h8001, 1'b0, 1'b0, 1, 0, 2, 8'h96);
        run_cycle(1'b1, 16'h4000, 1'b1, 1'b0, 2, 4, 0, 8'h11);
        run_cycle(1'b0, 16'h8F0F, 1'b0, 1'b1, 7, 0, 0, 8'hC3);

        // Abort a memory read in TW with rst.
        bus.ws_cfg = {4{3'd5}};
        @(posedge clk); #1;
        bus.ale   = 1'b1;
        bus.io_m  = 1'b0;
        bus.ad_in = 16'h4000;
        @(posedge clk); #1;
        bus.ale      = 1'b0;
        bus.rd_req_n = 1'b0;
        @(posedge clk); #1;
        bus.rd_req_n = 1'b1;
        @(posedge clk); #1;
        check_eq("tw_memr", bus.memr_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_strobes", {bus.ior_n, bus.iow_n, bus.memr_n, bus.memw_n}, 4'hF);
        check_eq("mid_rst_cs_n", bus.cs_n, 4'hF);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_vld", bus.rdata_vld, 0);
        rst = 1'b0;
        run_cycle(1'b0, 16'h4321, 1'b0, 1'b1, 2, 0, 0, 8'h77);

`ifdef BUS_TIMEOUT_EN
        run_cycle(1'b0, 16'h0040, 1'b0, 1'b1, 0, 100, 0, 8'hE7);
        check_eq("tmo_idle_err", bus.err, 0);
`else
        begin
            logic err_seen;
            err_seen     = 1'b0;
            bus.ws_cfg   = '0;
            bus.ready    = 1'b0;
            @(posedge clk); #1;
            bus.ale   = 1'b1;
            bus.io_m  = 1'b0;
            bus.ad_in = 16'h0040;
            @(posedge clk); #1;
            bus.ale      = 1'b0;
            bus.rd_req_n = 1'b0;
            @(posedge clk); #1;
            bus.rd_req_n = 1'b1;
            for (int i = 0; i < 80; i++) begin
                err_seen |= bus.err;
                @(posedge clk); #1;
            end
            check_eq("stuck_busy", bus.busy, 1);
            check_eq("stuck_memr", bus.memr_n, 0);
            check_eq("stuck_err", err_seen, 0);
            rst = 1'b1;
            @(posedge clk); #1;
            rst       = 1'b0;
            bus.ready = 1'b1;
            check_eq("stuck_rst_busy", bus.busy, 0);
        end
`endif

        repeat (2) @(posedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
